led_frame_sequencer: RTL



---
 rtl/led_strip_pkg.sv | 34 +++
 rtl/led_frame_sequencer_if.sv | 33 +++
 rtl/spi_byte_issuer.sv | 64 ++++++
 rtl/led_frame_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/led_strip_pkg.sv
`default_nettype none
// =============================================================================
// led_strip_pkg : shared constants and state types for the LED strip frame path
// Rev 1.0
// =============================================================================
package led_strip_pkg;

    localparam logic [2:0] LED_HDR_MARK      = 3'b111;
    localparam int         START_FRAME_BYTES = 4;
    localparam logic [7:0] START_FRAME_BYTE  = 8'h00;
    localparam logic [7:0] END_FRAME_BYTE    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LED   = 3'd4,
        ST_END   = 3'd5,
        ST_DONE  = 3'd6
    } frame_state_t;

    typedef enum logic [1:0] {
        IS_IDLE = 2'd0,
        IS_REQ  = 2'd1,
        IS_XFER = 2'd2
    } issue_state_t;

    function automatic logic [7:0] led_header(input logic [4:0] bright);
        return {LED_HDR_MARK, bright};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_sequencer_if.sv
`default_nettype none
// =============================================================================
// led_frame_sequencer_if : byte-writer handshake and pixel memory read port
// Rev 1.0
// =============================================================================
interface led_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 8
) ();

    logic                  spi_start;
    logic [7:0]            spi_data_in;
    logic                  spi_busy;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [23:0]           pix_data;

    modport master (
        output spi_start,
        output spi_data_in,
        input  spi_busy,
        output pix_addr,
        input  pix_data
    );

    modport slave (
        input  spi_start,
        input  spi_data_in,
        output spi_busy,
        input  pix_addr,
        output pix_data
    );

endinterface
`default_nettype wire

// File: rtl/spi_byte_issuer.sv
`default_nettype none
// =============================================================================
// spi_byte_issuer : runs the start/busy handshake for one byte at a time
// Rev 1.0
// =============================================================================
module spi_byte_issuer
    import led_strip_pkg::*;
(
    input  wire        clk,
    input  wire        rst_n,
    input  wire        byte_valid,
    input  wire  [7:0] byte_data,
    output logic       byte_ready,
    output logic       spi_start,
    output logic [7:0] spi_data_in,
    input  wire        spi_busy
);

    issue_state_t r_state;
    logic         r_start;
    logic [7:0]   r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IS_IDLE;
            r_start <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            case (r_state)
                IS_IDLE: begin
                    // A writer still busy from before reset holds us here.
                    if (byte_valid && !spi_busy) begin
                        r_start <= 1'b1;
                        r_data  <= byte_data;
                        r_state <= IS_REQ;
                    end
                end
                IS_REQ: begin
                    if (spi_busy) begin
                        r_start <= 1'b0;
                        r_state <= IS_XFER;
                    end
                end
                IS_XFER: begin
                    if (!spi_busy) begin
                        r_state <= IS_IDLE;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_state <= IS_IDLE;
                end
            endcase
        end
    end

    // Completion is flagged in the cycle busy is seen low so the presenter
    // can advance in lock-step with the return to idle.
    assign byte_ready  = (r_state == IS_XFER) && !spi_busy;
    assign spi_start   = r_start;
    assign spi_data_in = r_data;

endmodule
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// =============================================================================
// led_frame_sequencer : walks pixel memory and emits an APA102 frame byte stream
// Rev 1.0
// =============================================================================
module led_frame_sequencer
    import led_strip_pkg::*;
#(
    parameter int NUM_LEDS   = 60,
    parameter int ADDR_WIDTH = 8,
    parameter int END_BYTES  = 4
) (
    input  wire                   frame_clk,
    input  wire                   frame_reset_n,
    input  wire                   frame_go,
    input  wire  [4:0]            frame_brightness,
    output logic                  frame_busy,
    output logic                  frame_done,
    led_frame_sequencer_if.master bus
);

    localparam int END_CNT_W = $clog2(END_BYTES + 1);

    frame_state_t          r_state;
    logic [1:0]            r_byte_cnt;
    logic [END_CNT_W-1:0]  r_end_cnt;
    logic [ADDR_WIDTH-1:0] r_led_idx;
    logic [ADDR_WIDTH-1:0] r_pix_addr;
    logic [23:0]           r_pix;
    logic [4:0]            r_bright;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_byte_valid;
    logic [7:0]            w_byte_data;
    logic                  w_byte_ready;

    // The first start byte is offered in the accept cycle itself so that
    // spi_start rises on the same edge that raises frame_busy.
    always_comb begin
        w_byte_valid = 1'b0;
        w_byte_data  = START_FRAME_BYTE;
        case (r_state)
            ST_IDLE:  w_byte_valid = frame_go;
            ST_START: w_byte_valid = 1'b1;
            ST_LED: begin
                w_byte_valid = 1'b1;
                case (r_byte_cnt)
                    2'd0:    w_byte_data = led_header(r_bright);
                    2'd1:    w_byte_data = r_pix[7:0];
                    2'd2:    w_byte_data = r_pix[15:8];
                    default: w_byte_data = r_pix[23:16];
                endcase
            end
            ST_END: begin
                w_byte_valid = 1'b1;
                w_byte_data  = END_FRAME_BYTE;
            end
            default: w_byte_valid = 1'b0;
        endcase
    end

    always_ff @(posedge frame_clk or negedge frame_reset_n) begin
        if (!frame_reset_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= 2'd0;
            r_end_cnt  <= '0;
            r_led_idx  <= '0;
            r_pix_addr <= '0;
            r_pix      <= 24'h0;
            r_bright   <= 5'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_go) begin
                        r_bright   <= frame_brightness;
                        r_led_idx  <= '0;
                        r_byte_cnt <= 2'd0;
                        r_end_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_byte_ready) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'(START_FRAME_BYTES - 1)) begin
                            r_pix_addr <= r_led_idx;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_pix   <= bus.pix_data;
                    r_state <= ST_LED;
                end
                ST_LED: begin
                    if (w_byte_ready) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_led_idx == ADDR_WIDTH'(NUM_LEDS - 1)) begin
                                r_state <= ST_END;
                            end else begin
                                // Address leads the index so pix_data is ready in WAIT.
                                r_led_idx  <= r_led_idx + 1'b1;
                                r_pix_addr <= r_led_idx + 1'b1;
                                r_state    <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_END: begin
                    if (w_byte_ready) begin
                        if (r_end_cnt == END_CNT_W'(END_BYTES - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_end_cnt <= r_end_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spi_byte_issuer u_issuer (
        .clk         (frame_clk),
        .rst_n       (frame_reset_n),
        .byte_valid  (w_byte_valid),
        .byte_data   (w_byte_data),
        .byte_ready  (w_byte_ready),
        .spi_start   (bus.spi_start),
        .spi_data_in (bus.spi_data_in),
        .spi_busy    (bus.spi_busy)
    );

    assign bus.pix_addr = r_pix_addr;
    assign frame_busy   = r_busy;
    assign frame_done   = r_done;

endmodule
`default_nettype wire
